writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage, directly downstream of the memory stage. Captures the memory stage's result on its `memory_done` handshake and formats load data (byte/half/word/double extraction, sign or zero extension). Writes the register file through a ready/enable port and returns `mem_wb_pipeline_valid` to close the four-phase handshake with the memory stage.

## Interface
Parameters:
- `XLEN`, 64: datapath width.
- `REG_ADDR_W`, 5: register index width.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `memory_done`  in  1: memory stage result valid; held until `mem_wb_pipeline_valid` is seen.
- `loaded_data_out`  in  64: naturally aligned doubleword containing the load address.
- `alu_data`  in  64: ALU result; also the load/store address.
- `pc_plus_4`  in  64: link value for jumps.
- `control_signals`  in  struct: uses `read_memory_access`, `reg_write`, `link_write`, `load_unsigned`, `data_size[2:0]`, `dest_reg`.
- `rf_write_ready`  in  1: register-file write port free this cycle.
- `mem_wb_pipeline_valid`  out  1: result latched; feeds the memory stage.
- `rf_write_enable`  out  1: register-file write strobe.
- `rf_write_addr`  out  `REG_ADDR_W`: destination register.
- `rf_write_data`  out  64: write-back value.
- `wb_misaligned`  out  1: one-cycle pulse when a latched load crosses an 8-byte boundary.
- `instret`  out  64: retired-instruction count. Present only with `WB_INSTRET_EN`.

## Operation
- FSM states: IDLE, WRITE, RELEASE.
- **IDLE:** when `memory_done`=1, latch every input into the result register, set `mem_wb_pipeline_valid`=1, and go to WRITE.
- **WRITE:**
  - A write is needed when (`reg_write` or `link_write`) and `dest_reg`≠0 and the access is not misaligned.
  - If a write is needed, drive `rf_write_enable`=1 and hold it until a cycle with `rf_write_ready`=1. The write completes in that cycle. Go to RELEASE.
  - If no write is needed, go to RELEASE after one cycle.
- **RELEASE:** keep `mem_wb_pipeline_valid`=1 until `memory_done` is sampled 0. Then clear valid and return to IDLE.
  - This prevents recapturing the same result while the memory stage still holds `memory_done` high.
- Write-data selection, in priority order:
  1. `link_write` → `pc_plus_4`.
  2. `read_memory_access` → formatted load.
  3. Otherwise → `alu_data`.
- Load formatting:
  - `data_size` 000=byte, 001=half, 010=word, 011=double.
  - Byte offset is `alu_data[2:0]`; the selected field is shifted to bit 0.
  - The field is sign-extended unless `load_unsigned` is set.
- Misalignment: `offset + size_bytes` > 8.
  - Pulse `wb_misaligned` for the first WRITE cycle.
  - Suppress the register-file write.
  - The handshake still completes.
- `rf_write_addr` and `rf_write_data` come from the latched register, so they are stable throughout WRITE.

## Timing
- All outputs reset to 0; FSM resets to IDLE.
- Minimum 3 cycles per instruction: capture edge, WRITE cycle, then RELEASE exits on the first edge where `memory_done`=0.
- `mem_wb_pipeline_valid` rises the cycle after `memory_done` is sampled high.
- Each cycle of `rf_write_ready`=0 adds one WRITE cycle.
- Load formatting is combinational on latched data; no added latency.
- If `memory_done` falls while in WRITE, the write still completes. RELEASE then exits on its first cycle.
- Reset mid-WRITE aborts the write; no partial register-file update occurs after reset assertion.
- `memory_done` is ignored outside IDLE.

## Configuration
- `WB_INSTRET_EN` defined:
  - `instret` port exists.
  - It increments by 1 on leaving RELEASE, whether or not a register write occurred.
  - It wraps at 2^64 to 0 and resets to 0.
- `WB_INSTRET_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package:
  - `control_signals_struct` fields listed above.
  - `data_size` encodings: `SIZE_B`, `SIZE_H`, `SIZE_W`, `SIZE_D`.
  - FSM state enum `wb_state_t`.
- Sub-module `load_formatter`:
  - Combinational.
  - Inputs: 64-bit doubleword, offset, size, unsigned flag.
  - Outputs: 64-bit extended value and misaligned flag.

## Test plan
- **Signed byte load.** `loaded_data_out`=0x0000_0000_0080_0000, `alu_data`=0x1002, byte, signed, `dest_reg`=5, `rf_write_ready`=1.
  - Expect one `rf_write_enable` pulse with addr 5 and data 0xFFFF_FFFF_FFFF_FF80.
- **Unsigned half load.** Same data, `alu_data`=0x1002, half, unsigned → data 0x0000_0000_0000_0080.
- **Stalled register-file port.** ALU op with `dest_reg`=3, `alu_data`=0x1234, `rf_write_ready` low for 4 cycles.
  - Expect `rf_write_enable` held for 5 cycles with constant addr/data.
  - `mem_wb_pipeline_valid` stays high until `memory_done` drops.
- **Misaligned word load.** `alu_data`=0x1006.
  - Expect a one-cycle `wb_misaligned` pulse, no `rf_write_enable`, and the handshake completes.
- **Suppressed writes.** `dest_reg`=0 with `reg_write`=1 → no write.
  - Then `link_write` with `pc_plus_4`=0x8004 and `dest_reg`=1 → writes 0x8004.
- **Reset mid-write.** Assert `reset`=0 during WRITE with `rf_write_ready`=0.
  - Expect all outputs 0 immediately and state IDLE; with `WB_INSTRET_EN`, `instret`=0.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared types for the write-back stage: control bundle from the memory stage,
// load size encodings and the FSM state type.
package writeback_stage_pkg;

  localparam logic [2:0] SIZE_B = 3'b000;
  localparam logic [2:0] SIZE_H = 3'b001;
  localparam logic [2:0] SIZE_W = 3'b010;
  localparam logic [2:0] SIZE_D = 3'b011;

  typedef struct packed {
    logic       read_memory_access;
    logic       reg_write;
    logic       link_write;
    logic       load_unsigned;
    logic [2:0] data_size;
    logic [4:0] dest_reg;
  } control_signals_struct;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_WRITE   = 2'd1,
    WB_RELEASE = 2'd2
  } wb_state_t;

  // Encodings above SIZE_D are treated as a full doubleword.
  function automatic logic [3:0] size_in_bytes(input logic [2:0] size);
    return size[2] ? 4'd8 : 4'(4'd1 << size[1:0]);
  endfunction

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// load_formatter: extracts a byte/half/word/double from an aligned doubleword,
// right-justifies and sign/zero-extends it, and flags 8-byte boundary crossings.
module load_formatter
  import writeback_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] dword,
  input  logic [2:0]      offset,
  input  logic [2:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] value,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;
  logic [3:0]      size_bytes;

  always_comb begin
    shifted    = dword >> {offset, 3'b000};
    size_bytes = size_in_bytes(size);
    misaligned = ({1'b0, offset} + size_bytes) > 4'd8;
    unique case (size)
      SIZE_B:  value = {{(XLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      SIZE_H:  value = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
      SIZE_W:  value = {{(XLEN-32){~is_unsigned & shifted[31]}}, shifted[31:0]};
      SIZE_D:  value = shifted;
      default: value = shifted;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: captures the memory-stage result, formats loads and writes the
// register file. Define WB_INSTRET_EN to add the retired-instruction counter port.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_done,
  input  logic [XLEN-1:0]       loaded_data_out,
  input  logic [XLEN-1:0]       alu_data,
  input  logic [XLEN-1:0]       pc_plus_4,
  input  control_signals_struct control_signals,
  input  logic                  rf_write_ready,
  output logic                  mem_wb_pipeline_valid,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [XLEN-1:0]       rf_write_data,
  output logic                  wb_misaligned
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]           instret
`endif
);

  wb_state_t             state_q, state_d;
  logic                  valid_q, valid_d;
  logic                  first_q, first_d;
  control_signals_struct ctrl_q, ctrl_d;
  logic [XLEN-1:0]       load_q, load_d;
  logic [XLEN-1:0]       alu_q, alu_d;
  logic [XLEN-1:0]       pc4_q, pc4_d;

  logic [XLEN-1:0]       load_value;
  logic                  load_misaligned;
  logic                  misaligned;
  logic                  write_needed;

  load_formatter #(.XLEN(XLEN)) u_load_formatter (
    .dword      (load_q),
    .offset     (alu_q[2:0]),
    .size       (ctrl_q.data_size),
    .is_unsigned(ctrl_q.load_unsigned),
    .value      (load_value),
    .misaligned (load_misaligned)
  );

  // Only loads can be misaligned; the ALU result of other ops is not an address.
  assign misaligned   = ctrl_q.read_memory_access & load_misaligned;
  assign write_needed = (ctrl_q.reg_write | ctrl_q.link_write)
                      & (ctrl_q.dest_reg != '0) & ~misaligned;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d = state_q;
    valid_d = valid_q;
    first_d = 1'b0;
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    alu_d   = alu_q;
    pc4_d   = pc4_q;
    unique case (state_q)
      WB_IDLE: begin
        if (memory_done) begin
          ctrl_d  = control_signals;
          load_d  = loaded_data_out;
          alu_d   = alu_data;
          pc4_d   = pc_plus_4;
          valid_d = 1'b1;
          first_d = 1'b1;
          state_d = WB_WRITE;
        end
      end
      WB_WRITE: begin
        if (!write_needed || rf_write_ready) state_d = WB_RELEASE;
      end
      WB_RELEASE: begin
        // Hold valid until the memory stage drops done, so the result is not recaptured.
        if (!memory_done) begin
          valid_d = 1'b0;
          state_d = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WB_IDLE;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      // NOTE: the result register is reset because rf_write_addr/data must read 0 out of reset.
      ctrl_q  <= '0;
      load_q  <= '0;
      alu_q   <= '0;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      first_q <= first_d;
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      alu_q   <= alu_d;
      pc4_q   <= pc4_d;
    end
  end

  always_comb begin
    if (ctrl_q.link_write)              rf_write_data = pc4_q;
    else if (ctrl_q.read_memory_access) rf_write_data = load_value;
    else                                rf_write_data = alu_q;
  end

  assign mem_wb_pipeline_valid = valid_q;
  assign rf_write_enable       = (state_q == WB_WRITE) & write_needed;
  assign rf_write_addr         = REG_ADDR_W'(ctrl_q.dest_reg);
  assign wb_misaligned         = (state_q == WB_WRITE) & first_q & misaligned;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q;
    if (state_q == WB_RELEASE && !memory_done) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a driver issues transactions and queues the
// expected register-file events; a monitor pops and compares them as they appear.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  memory_done;
  logic [63:0]           loaded_data_out;
  logic [63:0]           alu_data;
  logic [63:0]           pc_plus_4;
  control_signals_struct control_signals;
  logic                  rf_write_ready;
  logic                  mem_wb_pipeline_valid;
  logic                  rf_write_enable;
  logic [4:0]            rf_write_addr;
  logic [63:0]           rf_write_data;
  logic                  wb_misaligned;
`ifdef WB_INSTRET_EN
  logic [63:0]           instret;
`endif

  writeback_stage #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk                  (clk),
    .reset                (reset),
    .memory_done          (memory_done),
    .loaded_data_out      (loaded_data_out),
    .alu_data             (alu_data),
    .pc_plus_4            (pc_plus_4),
    .control_signals      (control_signals),
    .rf_write_ready       (rf_write_ready),
    .mem_wb_pipeline_valid(mem_wb_pipeline_valid),
    .rf_write_enable      (rf_write_enable),
    .rf_write_addr        (rf_write_addr),
    .rf_write_data        (rf_write_data),
    .wb_misaligned        (wb_misaligned)
`ifdef WB_INSTRET_EN
    ,
    .instret              (instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mis;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          en_cycles = 0;
  int          mis_cycles = 0;
  logic [63:0] model_instret = '0;
  logic        prev_en = 1'b0;
  logic [4:0]  prev_addr = '0;
  logic [63:0] prev_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic control_signals_struct mk_ctrl(input bit rd, input bit rw, input bit lw,
                                                    input bit uns, input logic [2:0] size,
                                                    input logic [4:0] dest);
    control_signals_struct c;
    c.read_memory_access = rd;
    c.reg_write          = rw;
    c.link_write         = lw;
    c.load_unsigned      = uns;
    c.data_size          = size;
    c.dest_reg           = dest;
    return c;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rf_write_enable) begin
        en_cycles++;
        if (prev_en) begin
          check("stall_addr_stable", 64'(rf_write_addr), 64'(prev_addr));
          check("stall_data_stable", rf_write_data, prev_data);
        end
        if (rf_write_ready) begin
          check("write_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("event_is_write", 64'(e.is_mis), 64'd0);
            check("write_addr", 64'(rf_write_addr), 64'(e.addr));
            check("write_data", rf_write_data, e.data);
          end
        end
      end
      if (wb_misaligned) begin
        mis_cycles++;
        check("misaligned_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("event_is_misaligned", 64'(e.is_mis), 64'd1);
        end
      end
      prev_en   = rf_write_enable;
      prev_addr = rf_write_addr;
      prev_data = rf_write_data;
    end
  end

  // One full instruction: capture, write (with stall cycles of ready low), release after
  // memory_done has been held for `hold` cycles past capture.
  task automatic run_txn(input control_signals_struct c, input logic [63:0] ld,
                         input logic [63:0] alu, input logic [63:0] pc4,
                         input int stall, input int hold);
    int          nbytes, off, k, wcyc, exp_k;
    logic [63:0] mask, field, data;
    bit          mis, wr, done;
    exp_t        e;

    nbytes = 1 << c.data_size;
    off    = int'(alu[2:0]);
    mis    = c.read_memory_access && (off + nbytes > 8);
    mask   = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
    field  = (ld >> (8 * off)) & mask;
    if (!c.load_unsigned && field[8 * nbytes - 1]) field = field | ~mask;
    data   = c.link_write ? pc4 : (c.read_memory_access ? field : alu);
    wr     = (c.reg_write || c.link_write) && (c.dest_reg != 0) && !mis;
    if (mis) begin e.is_mis = 1'b1; e.addr = '0; e.data = '0; sb.push_back(e); end
    if (wr)  begin e.is_mis = 1'b0; e.addr = c.dest_reg; e.data = data; sb.push_back(e); end

    @(posedge clk); #1;
    check("valid_low_before_capture", 64'(mem_wb_pipeline_valid), 64'd0);
    control_signals = c;
    loaded_data_out = ld;
    alu_data        = alu;
    pc_plus_4       = pc4;
    memory_done     = 1'b1;
    en_cycles       = 0;
    mis_cycles      = 0;

    @(posedge clk); #1;
    check("valid_rise", 64'(mem_wb_pipeline_valid), 64'd1);
    // Scramble inputs: the stage must work from its latched copy.
    control_signals = control_signals_struct'($urandom);
    loaded_data_out = {$urandom, $urandom};
    alu_data        = {$urandom, $urandom};
    pc_plus_4       = {$urandom, $urandom};

    k    = 0;
    done = 1'b0;
    while (!done && k < 60) begin
      rf_write_ready = (k >= stall);
      memory_done    = (k < hold);
      @(posedge clk); #1;
      k++;
      if (!mem_wb_pipeline_valid) done = 1'b1;
    end
    memory_done = 1'b0;
    check("handshake_completes", 64'(done), 64'd1);

    wcyc  = wr ? stall : 0;
    exp_k = ((wcyc + 1 > hold) ? wcyc + 1 : hold) + 1;
    check("release_cycle", 64'(k), 64'(exp_k));
    check("enable_cycles", 64'(en_cycles), wr ? 64'(stall + 1) : 64'd0);
    check("misaligned_cycles", 64'(mis_cycles), mis ? 64'd1 : 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    model_instret = model_instret + 64'd1;
`ifdef WB_INSTRET_EN
    check("instret", instret, model_instret);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(mem_wb_pipeline_valid), 64'd0);
    check({tag, "_enable"}, 64'(rf_write_enable), 64'd0);
    check({tag, "_addr"}, 64'(rf_write_addr), 64'd0);
    check({tag, "_data"}, rf_write_data, 64'd0);
    check({tag, "_misaligned"}, 64'(wb_misaligned), 64'd0);
`ifdef WB_INSTRET_EN
    check({tag, "_instret"}, instret, 64'd0);
`endif
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    control_signals_struct c;
    reset           = 1'b0;
    memory_done     = 1'b0;
    loaded_data_out = '0;
    alu_data        = '0;
    pc_plus_4       = '0;
    control_signals = '0;
    rf_write_ready  = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Signed byte load and unsigned half load from the same doubleword.
    run_txn(mk_ctrl(1, 1, 0, 0, SIZE_B, 5), 64'h0000_0000_0080_0000, 64'h1002, 64'h0, 0, 1);
    run_txn(mk_ctrl(1, 1, 0, 1, SIZE_H, 5), 64'h0000_0000_0080_0000, 64'h1002, 64'h0, 0, 1);
    // Register-file port busy for four cycles.
    run_txn(mk_ctrl(0, 1, 0, 0, SIZE_D, 3), 64'h0, 64'h1234, 64'h0, 4, 2);
    // Misaligned word load.
    run_txn(mk_ctrl(1, 1, 0, 0, SIZE_W, 5), 64'h1122_3344_5566_7788, 64'h1006, 64'h0, 0, 1);
    // x0 destination, then a link write.
    run_txn(mk_ctrl(0, 1, 0, 0, SIZE_D, 0), 64'h0, 64'h55AA, 64'h0, 0, 1);
    run_txn(mk_ctrl(0, 0, 1, 0, SIZE_D, 1), 64'h0, 64'h7777, 64'h8004, 0, 1);
    // memory_done dropped while still stalled in WRITE.
    run_txn(mk_ctrl(1, 1, 0, 0, SIZE_D, 9), 64'h8000_0000_DEAD_BEEF, 64'h2000, 64'h0, 3, 1);

    // Reset asserted mid-WRITE with the port stalled.
    @(posedge clk); #1;
    control_signals = mk_ctrl(0, 1, 0, 0, SIZE_D, 7);
    alu_data        = 64'hABCD;
    memory_done     = 1'b1;
    rf_write_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_enable", 64'(rf_write_enable), 64'd1);
    reset         = 1'b0;
    memory_done   = 1'b0;
    model_instret = '0;
    #1;
    check_all_zero("midwrite_reset");
    rf_write_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check_all_zero("after_reset");

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      c.read_memory_access = 1'($urandom);
      c.reg_write          = 1'($urandom);
      c.link_write         = ($urandom_range(0, 4) == 0);
      c.load_unsigned      = 1'($urandom);
      c.data_size          = 3'($urandom_range(0, 3));
      c.dest_reg           = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      run_txn(c, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(1, 4));
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
